// File: rtl/qam_tx_frame_ctrl.sv
// qam_tx_frame_ctrl
// Frame sequencer for the QAM16 transmit chain. Every frame is a fixed
// alternating 3/C preamble, then payload nibbles pulled from upstream, then
// zero symbols that drain the RRC filters. One symbol is issued per SPS
// clock cycles, and the phase count drives the upsampler.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   start, frame_len  frame request (honoured only when idle) and payload length
//   in_data/in_valid  upstream payload nibble and its valid flag
//   in_ready          upstream transfer happens this cycle
//   sym_data          symbol to the mapper, held for the whole symbol period
//   sym_strobe        one-cycle pulse at phase 0 of every symbol period
//   phase             upsampler phase count, 0..SPS-1
//   tx_en, busy       frame in progress
//   done              one-cycle pulse in the first idle cycle after a frame
//   underrun          sticky flag: a payload slot had no data
module qam_tx_frame_ctrl #(
    parameter int SPS       = 4,
    parameter int PRE_LEN   = 8,
    parameter int FLUSH_LEN = 11,
    parameter int LEN_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    input  logic [3:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [3:0]       sym_data,
    output logic             sym_strobe,
    output logic [3:0]       phase,
    output logic             tx_en,
    output logic             busy,
    output logic             done,
    output logic             underrun
);

    typedef enum logic [1:0] {IDLE, PRE, PAY, FLUSH} state_t;

    localparam int CNT_MAX = (PRE_LEN > FLUSH_LEN) ? PRE_LEN : FLUSH_LEN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [3:0]       PH_LAST    = 4'(SPS - 1);
    localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(PRE_LEN - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_LEN - 1);

    state_t             state_q, state_d;
    logic [3:0]         phase_q, phase_d;
    logic [CNT_W-1:0]   sym_cnt_q, sym_cnt_d;
    logic [LEN_W-1:0]   pay_cnt_q, pay_cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [3:0]         sym_q, sym_d;
    logic               under_q, under_d;
    logic               done_q, done_d;
    logic               boundary;
    logic               take;

    // State and datapath registers; every register clears on reset so an
    // aborted frame leaves no done pulse or stale symbol behind.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            sym_cnt_q <= '0;
            pay_cnt_q <= '0;
            len_q     <= '0;
            sym_q     <= '0;
            under_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            sym_cnt_q <= sym_cnt_d;
            pay_cnt_q <= pay_cnt_d;
            len_q     <= len_d;
            sym_q     <= sym_d;
            under_q   <= under_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic. All state and symbol changes happen on the edge that
    // leaves phase SPS-1, so a new symbol always appears together with phase 0.
    // 'take' marks the cycle that precedes a payload period: that is the only
    // cycle in which upstream is offered a transfer.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        sym_cnt_d = sym_cnt_q;
        pay_cnt_d = pay_cnt_q;
        len_d     = len_q;
        sym_d     = sym_q;
        under_d   = under_q;
        done_d    = 1'b0;
        take      = 1'b0;
        in_ready  = 1'b0;
        boundary  = (phase_q == PH_LAST);

        if (state_q != IDLE) begin
            phase_d = boundary ? 4'd0 : phase_q + 4'd1;
        end

        case (state_q)
            IDLE: begin
                phase_d = 4'd0;
                if (start) begin
                    state_d   = PRE;
                    sym_cnt_d = '0;
                    pay_cnt_d = '0;
                    len_d     = frame_len;
                    under_d   = 1'b0;
                    sym_d     = 4'h3;
                end
            end
            PRE: begin
                if (boundary) begin
                    if (sym_cnt_q == PRE_LAST) begin
                        if (len_q != '0) begin
                            state_d   = PAY;
                            pay_cnt_d = '0;
                            take      = 1'b1;
                        end else begin
                            state_d   = FLUSH;
                            sym_cnt_d = '0;
                            sym_d     = 4'h0;
                        end
                    end else begin
                        // Current index even means the next one is odd (4'hC).
                        sym_cnt_d = sym_cnt_q + 1'b1;
                        sym_d     = sym_cnt_q[0] ? 4'h3 : 4'hC;
                    end
                end
            end
            PAY: begin
                if (boundary) begin
                    if (pay_cnt_q == len_q - LEN_W'(1)) begin
                        state_d   = FLUSH;
                        sym_cnt_d = '0;
                        sym_d     = 4'h0;
                    end else begin
                        pay_cnt_d = pay_cnt_q + LEN_W'(1);
                        take      = 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (boundary) begin
                    if (sym_cnt_q == FLUSH_LAST) begin
                        state_d = IDLE;
                        phase_d = 4'd0;
                        done_d  = 1'b1;
                        sym_d   = 4'h0;
                    end else begin
                        sym_cnt_d = sym_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A missing upstream symbol still consumes its slot so frame timing
        // never stretches; the slot carries a zero symbol instead.
        if (take) begin
            in_ready = 1'b1;
            sym_d    = in_valid ? in_data : 4'h0;
            if (!in_valid) begin
                under_d = 1'b1;
            end
        end
    end

    assign sym_data   = sym_q;
    assign phase      = phase_q;
    assign busy       = (state_q != IDLE);
    assign tx_en      = busy;
    assign sym_strobe = busy && (phase_q == 4'd0);
    assign done       = done_q;
    assign underrun   = under_q;

endmodule

// File: tb/tb_qam_tx_frame_ctrl.sv
// tb_qam_tx_frame_ctrl
// Self-checking bench for qam_tx_frame_ctrl. A behavioural model describes a
// frame purely by its start cycle and length: from the cycle offset it derives
// symbol index and phase, and from those the expected outputs. A compare
// process checks every output on every falling edge; directed scenarios add
// hand-computed literal checks for the default parameters.
module tb_qam_tx_frame_ctrl;

    localparam int SPS   = 4;
    localparam int PRE   = 8;
    localparam int FLUSH = 11;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [LEN_W-1:0] frame_len;
    logic [3:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       sym_data;
    logic             sym_strobe;
    logic [3:0]       phase;
    logic             tx_en;
    logic             busy;
    logic             done;
    logic             underrun;

    int total = 0;
    int bad   = 0;

    qam_tx_frame_ctrl #(
        .SPS(SPS), .PRE_LEN(PRE), .FLUSH_LEN(FLUSH), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .frame_len(frame_len),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .sym_data(sym_data), .sym_strobe(sym_strobe), .phase(phase),
        .tx_en(tx_en), .busy(busy), .done(done), .underrun(underrun)
    );

    always #5 clk = ~clk;

    // Reference model state: a frame is just its first cycle and its length.
    int         cyc = 0;
    bit         model_valid = 1'b0;
    bit         m_active = 1'b0;
    int         m_first = 0;
    int         m_len = 0;
    int         done_cyc = -1;
    bit         m_under = 1'b0;
    logic [3:0] pay_mem [0:255];

    task automatic check_output(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Model update on the same edge the DUT samples its inputs on; cyc then
    // names the cycle that follows this edge.
    always @(posedge clk) begin
        bit was_active;
        int c, k, ph;
        cyc++;
        was_active = m_active;
        if (reset) begin
            m_active    = 1'b0;
            m_under     = 1'b0;
            done_cyc    = -1;
            model_valid = 1'b1;
        end else begin
            if (m_active) begin
                c  = (cyc - 1) - m_first;
                k  = c / SPS;
                ph = c % SPS;
                if (ph == SPS - 1 && k + 1 >= PRE && k + 1 < PRE + m_len) begin
                    pay_mem[k + 1 - PRE] = in_valid ? in_data : 4'h0;
                    if (!in_valid) m_under = 1'b1;
                end
                if (cyc == m_first + (PRE + m_len + FLUSH) * SPS) begin
                    m_active = 1'b0;
                    done_cyc = cyc;
                end
            end
            if (!was_active && start) begin
                m_active = 1'b1;
                m_first  = cyc;
                m_len    = int'(frame_len);
                m_under  = 1'b0;
            end
        end
    end

    // Compare process: expected outputs follow from symbol index and phase.
    always @(negedge clk) begin
        int c, k, ph;
        logic [3:0] e_sym;
        logic e_ready;
        if (model_valid) begin
            if (m_active) begin
                c  = cyc - m_first;
                k  = c / SPS;
                ph = c % SPS;
                if (k < PRE)                e_sym = k[0] ? 4'hC : 4'h3;
                else if (k < PRE + m_len)   e_sym = pay_mem[k - PRE];
                else                        e_sym = 4'h0;
                e_ready = (ph == SPS - 1) && (k + 1 >= PRE) && (k + 1 < PRE + m_len);
                check_output("busy", 8'(busy), 8'd1);
                check_output("tx_en", 8'(tx_en), 8'd1);
                check_output("phase", 8'(phase), 8'(ph));
                check_output("sym_strobe", 8'(sym_strobe), 8'(ph == 0));
                check_output("sym_data", 8'(sym_data), 8'(e_sym));
                check_output("in_ready", 8'(in_ready), 8'(e_ready));
            end else begin
                check_output("busy", 8'(busy), 8'd0);
                check_output("tx_en", 8'(tx_en), 8'd0);
                check_output("phase", 8'(phase), 8'd0);
                check_output("sym_strobe", 8'(sym_strobe), 8'd0);
                check_output("sym_data", 8'(sym_data), 8'd0);
                check_output("in_ready", 8'(in_ready), 8'd0);
            end
            check_output("done", 8'(done), 8'(cyc == done_cyc));
            check_output("underrun", 8'(underrun), 8'(m_under));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs random traffic until the model goes idle, within a cycle budget.
    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while (m_active && n < budget) begin
            start     = 1'b0;
            frame_len = LEN_W'($urandom);
            in_data   = 4'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            tick();
            n++;
        end
        total++;
        if (m_active) begin
            bad++;
            $display("[TB] FAIL idle_timeout: still busy after %0d cycles, required idle", budget);
        end
    endtask

    // Directed frame with literal expectations for the default parameters.
    // drop_n: cycle with in_valid low; busy_start_n: stray start while busy;
    // reset_n: cycle in which reset is asserted; restart: start in done cycle.
    task automatic apply_stimulus(input int len, input int drop_n, input int busy_start_n,
                                  input int reset_n, input bit restart);
        int done_n, end_n, ir_count;
        done_n   = 1 + (PRE + len + FLUSH) * SPS;
        end_n    = (reset_n != 0) ? reset_n + 60 : done_n;
        ir_count = 0;
        frame_len = LEN_W'(len);
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n <= end_n; n++) begin
            if (in_ready) ir_count++;
            if (reset_n == 0 || n < reset_n) begin
                if (n == 1) begin
                    check_output("lit_first_strobe", 8'(sym_strobe), 8'd1);
                    check_output("lit_first_sym", 8'(sym_data), 8'h3);
                    check_output("lit_first_phase", 8'(phase), 8'd0);
                    check_output("lit_start_clears_underrun", 8'(underrun), 8'd0);
                end
                if (n == 5)  check_output("lit_pre1", 8'(sym_data), 8'hC);
                if (n == 29) check_output("lit_pre7", 8'(sym_data), 8'hC);
                if (len == 3) begin
                    if (n == 32 || n == 36 || n == 40)
                        check_output("lit_in_ready", 8'(in_ready), 8'd1);
                    if (n == 33) check_output("lit_pay0", 8'(sym_data), 8'h5);
                    if (n == 37) check_output("lit_pay1", 8'(sym_data), (drop_n != 0) ? 8'h0 : 8'hA);
                    if (n == 41) check_output("lit_pay2", 8'(sym_data), 8'hC);
                    if (n == 45) check_output("lit_flush0", 8'(sym_data), 8'h0);
                end
                if (n == done_n - 1) check_output("lit_done_early", 8'(done), 8'd0);
                if (n == done_n) begin
                    check_output("lit_done", 8'(done), 8'd1);
                    check_output("lit_underrun", 8'(underrun), 8'(drop_n != 0));
                    check_output("lit_in_ready_count", 8'(ir_count), 8'(len));
                end
            end else begin
                if (n == reset_n + 1) begin
                    check_output("lit_rst_busy", 8'(busy), 8'd0);
                    check_output("lit_rst_sym", 8'(sym_data), 8'd0);
                    check_output("lit_rst_tx_en", 8'(tx_en), 8'd0);
                end
                if (n == done_n) check_output("lit_rst_no_done", 8'(done), 8'd0);
            end
            start     = (n == busy_start_n) || (restart && n == done_n);
            frame_len = (restart && n == done_n) ? LEN_W'(0) : LEN_W'($urandom);
            in_data   = (n == 32) ? 4'h5 : (n == 36) ? 4'hA : (n == 40) ? 4'hC : 4'($urandom);
            in_valid  = (n != drop_n);
            reset     = (reset_n != 0 && n == reset_n);
            tick();
        end
        start = 1'b0;
        reset = 1'b0;
        if (restart) begin
            check_output("lit_restart_strobe", 8'(sym_strobe), 8'd1);
            check_output("lit_restart_phase", 8'(phase), 8'd0);
            check_output("lit_restart_busy", 8'(busy), 8'd1);
            run_until_idle(500);
        end
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        frame_len = '0;
        in_data   = '0;
        in_valid  = 1'b0;

        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("lit_reset_busy", 8'(busy), 8'd0);
            check_output("lit_reset_sym", 8'(sym_data), 8'd0);
            check_output("lit_reset_done", 8'(done), 8'd0);
        end
        reset = 1'b0;
        tick();
        tick();
        check_output("lit_idle_busy", 8'(busy), 8'd0);
        check_output("lit_idle_strobe", 8'(sym_strobe), 8'd0);

        apply_stimulus(3, 0, 0, 0, 1'b0);
        apply_stimulus(0, 0, 0, 0, 1'b0);
        apply_stimulus(3, 36, 0, 0, 1'b0);
        apply_stimulus(3, 0, 20, 0, 1'b1);
        apply_stimulus(3, 0, 0, 38, 1'b0);
        apply_stimulus(3, 0, 0, 0, 1'b0);

        // Randomized frames; a new start is issued as soon as the model is
        // idle, which is often the done cycle itself.
        for (int f = 0; f < 12; f++) begin
            start     = 1'b1;
            frame_len = (f == 0) ? LEN_W'(255) : LEN_W'($urandom_range(0, 12));
            in_data   = 4'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            tick();
            start = 1'b0;
            run_until_idle(2000);
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) tick();
        end
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/qam_tx_frame_ctrl.md
Name: qam_tx_frame_ctrl

Overview:
Frame sequencer for the QAM16 transmit chain. It sits ahead of the symbol mapper and upsampler, and drives them with one 4-bit symbol per symbol period plus the phase count the upsampler needs. Each frame is a fixed preamble, then payload symbols pulled from an upstream source over a valid/ready handshake, then zero symbols that drain the RRC filters. It reports busy, done and underrun status.

Parameters:
SPS, 4, samples per symbol (1..16); phase counts 0..SPS-1
PRE_LEN, 8, preamble length in symbols (>=1)
FLUSH_LEN, 11, zero-symbol flush length (>=1); equals the RRC TAPS value
LEN_W, 8, width of the frame_len port

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  frame request; sampled only in IDLE
frame_len  in  LEN_W  payload symbol count; latched on accepted start; 0 means no payload
in_data  in  4  payload symbol (4-bit nibble for the mapper)
in_valid  in  1  upstream has a symbol
in_ready  out  1  controller takes in_data this cycle
sym_data  out  4  symbol to the mapper; held for the whole symbol period
sym_strobe  out  1  one-cycle pulse at phase==0 of every symbol period
phase  out  4  upsampler count, 0..SPS-1
tx_en  out  1  high in PRE, PAY and FLUSH
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse when a frame completes
underrun  out  1  sticky; set when a payload slot has no data

Behaviour:
- Clock and reset: one clock (clk). reset is synchronous and active-high. On reset: state=IDLE; all outputs 0; internal counters 0; underrun cleared. Reset mid-frame aborts the frame on the next edge with no done pulse.
- States: IDLE, PRE, PAY, FLUSH.
- IDLE:
  - phase=0; sym_data=0; sym_strobe=0; tx_en=0; busy=0.
  - start=1: latch frame_len, clear underrun, go to PRE with phase=0.
- Phase counter: in non-IDLE states, increments each cycle and wraps SPS-1 -> 0. Symbol boundaries occur at phase==0. State changes take effect only at boundaries, i.e. on the edge leaving phase==SPS-1.
- PRE: preamble symbol k (k=0..PRE_LEN-1) is 4'h3 when k is even and 4'hC when k is odd. After PRE_LEN symbols, go to PAY if the latched len>0, otherwise FLUSH.
- PAY:
  - in_ready=1 only in the phase==SPS-1 cycle of any symbol period immediately followed by a payload period. This includes the last PRE period when len>0.
  - If in_valid=1 in that cycle, the transfer occurs and in_data becomes sym_data at the next phase 0.
  - If in_valid=0, sym_data=0 for that slot and underrun is set. The slot is still consumed, so frame timing never stretches.
  - After len slots, go to FLUSH.
- FLUSH: sym_data=0 for FLUSH_LEN symbols. The edge leaving the final phase==SPS-1 enters IDLE with done=1 for exactly that first IDLE cycle.
- Timing: start accepted at cycle t gives the first sym_strobe at t+1 and done at t+1+(PRE_LEN+len+FLUSH_LEN)*SPS.
- Boundary conditions:
  - start while busy is ignored.
  - start during the done cycle is accepted, so PRE begins on the next cycle.
  - in_ready is never asserted outside the rule above.
  - underrun stays set after done and clears only on reset or the next accepted start.
- Width rule: the payload counter is LEN_W bits. frame_len=2^LEN_W-1 must work without wrap.

Test Plan:
- Assert reset 3 cycles -> all outputs 0 and state IDLE. Deassert with start=0 -> outputs stay 0.
- Defaults; start at t with frame_len=3 and in_valid held 1 (data 5, A, C):
  - strobes at t+1, t+5, …; symbols 0–7 alternate 3/C; symbols 8–10 are 5/A/C.
  - in_ready pulses exactly 3 times, at t+32, t+36, t+40.
  - sym_data=0 for symbols 11–21; done at t+89; underrun=0.
- frame_len=0 -> 19 symbols (8 preamble, 11 zero), in_ready never high, done at t+77.
- frame_len=3 with in_valid=0 in the second in_ready cycle -> symbol 9 is 0, underrun=1 and held after done, done still at t+89. The next start clears underrun.
- start pulsed at t+20 during a frame -> ignored, done timing unchanged. start in the done cycle -> PRE strobe on the following cycle with phase=0.
- reset asserted during PAY (symbol 9) -> next cycle IDLE, all outputs 0, no done pulse. A fresh start then runs a normal frame.
